pi_permutation_func: RTL and testbench



---
 rtl/pi_permutation_func_if.sv | 35 +++
 rtl/pi_permutation_func.sv | 103 ++++++++++
 tb/tb_pi_permutation_func.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pi_permutation_func_if.sv
// rtl/pi_permutation_func_if.sv - slice memory / result sink signal bundle for the pi permutation streamer
interface pi_permutation_func_if;
   logic         start;
   logic [95:0]  input_file_name;
   logic [103:0] output_file_name;
   logic [24:0]  line_in;
   logic [6:0]   cnt_value;
   logic         write_enable;
   logic [24:0]  write_value;
   logic         donee;

   // Environment side: drives start, the tags and the memory read data
   modport master (
      output start,
      output input_file_name,
      output output_file_name,
      output line_in,
      input  cnt_value,
      input  write_enable,
      input  write_value,
      input  donee
   );

   // Permutation engine side
   modport slave (
      input  start,
      input  input_file_name,
      input  output_file_name,
      input  line_in,
      output cnt_value,
      output write_enable,
      output write_value,
      output donee
   );
endinterface

// File: rtl/pi_permutation_func.sv
// rtl/pi_permutation_func.sv - streams 64 Keccak slices through the pi lane permutation
module pi_permutation_func (
   input  logic                   clk,
   input  logic                   rst,
   pi_permutation_func_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Slice addresses are offset by 63: 63 addresses slice 0, 126 addresses slice 63.
   localparam logic [6:0] CNT_FIRST = 7'd63;
   localparam logic [6:0] CNT_LAST  = 7'd126;

   state_t      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [24:0] wv_q, wv_d;
   logic        done_q, done_d;
   logic [24:0] permuted;

   // The file name tags are carried for the surrounding flow only.
   logic unused_tags;
   assign unused_tags = ^{bus.input_file_name, bus.output_file_name};

   // Pure rewiring: out[5y+x] = in[5x + ((x+3y) mod 5)]
   genvar gx, gy;
   generate
      for (gy = 0; gy < 5; gy++) begin : g_row
         for (gx = 0; gx < 5; gx++) begin : g_col
            assign permuted[5*gy + gx] = bus.line_in[5*gx + ((gx + 3*gy) % 5)];
         end
      end
   endgenerate

   // State and output registers; every output is driven straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= CNT_FIRST;
         we_q    <= 1'b0;
         wv_q    <= 25'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         wv_q    <= wv_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output decode; register values are what the next state presents.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      wv_d    = wv_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            cnt_d  = CNT_FIRST;
            done_d = 1'b0;
            if (bus.start) begin
               state_d = READ;
            end
         end
         READ: begin
            // line_in is addressed by the current cnt_value and sampled here.
            wv_d    = permuted;
            we_d    = 1'b1;
            state_d = WRITE;
         end
         WRITE: begin
            // write_enable drops on leaving WRITE, so every pulse is one cycle wide.
            if (cnt_q == CNT_LAST) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + 7'd1;
               state_d = READ;
            end
         end
         DONE: begin
            // Sticky until reset, regardless of start.
            done_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.cnt_value    = cnt_q;
   assign bus.write_enable = we_q;
   assign bus.write_value  = wv_q;
   assign bus.donee        = done_q;

endmodule

// File: tb/tb_pi_permutation_func.sv
// tb/tb_pi_permutation_func.sv - directed self-checking bench for pi_permutation_func
module tb_pi_permutation_func;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pi_permutation_func_if bus ();

   pi_permutation_func dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [24:0] mem [64];
   logic [6:0]  addr_off;
   int          total = 0;
   int          bad   = 0;
   int          pulse_idx = 0;
   logic        prev_we = 1'b0;
   logic [24:0] cap [$];

   // Combinational slice memory, addressed with the 63 offset
   assign addr_off    = bus.cnt_value - 7'd63;
   assign bus.line_in = (bus.cnt_value >= 7'd63 && bus.cnt_value <= 7'd126) ? mem[addr_off[5:0]] : 25'd0;

   // Reference pi on a 5x5 lane grid: lane (x,y) of the output takes lane ((x+3y) mod 5, x) of the input
   function automatic logic [24:0] pi_ref(input logic [24:0] s);
      logic a [5][5];
      logic [24:0] r;
      r = '0;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            a[x][y] = s[5*y + x];
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            r[5*y + x] = a[(x + 3*y) % 5][x];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare process: every pulse against the model, plus DONE-state invariants
   always @(posedge clk) begin
      #1;
      if (rst) begin
         pulse_idx = 0;
         prev_we   = 1'b0;
         cap.delete();
      end else begin
         if (bus.write_enable) begin
            check("we_gap", {31'd0, prev_we}, 32'd0);
            if (pulse_idx < 64) begin
               check("pulse_value", {7'd0, bus.write_value}, {7'd0, pi_ref(mem[pulse_idx])});
               check("pulse_cnt", {25'd0, bus.cnt_value}, 32'(63 + pulse_idx));
            end else begin
               check("extra_pulse", 32'(pulse_idx), 32'd63);
            end
            cap.push_back(bus.write_value);
            pulse_idx++;
         end
         if (bus.donee) begin
            check("done_we", {31'd0, bus.write_enable}, 32'd0);
            check("done_cnt", {25'd0, bus.cnt_value}, 32'd126);
            check("done_early", 32'(pulse_idx), 32'd64);
         end
         prev_we = bus.write_enable;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Start a run, optionally dropping start right after it is sampled, and time donee.
   // donee must appear after the 128th edge following the sampling edge (cycle 129).
   task automatic run_full(input string name, input bit hold_start);
      int  cyc;
      bit  got;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      if (!hold_start) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      cyc = 0;
      got = 0;
      while (cyc < 400 && !got) begin
         @(posedge clk);
         #2;
         cyc++;
         if (bus.donee) got = 1;
      end
      if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
      check({name, "_done_latency"}, 32'(cyc), 32'd128);
      check({name, "_pulses"}, 32'(pulse_idx), 32'd64);
      bus.start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.input_file_name  = "slices_in.tx";
      bus.output_file_name = "slices_out.txt";
      for (int i = 0; i < 64; i++) mem[i] = 25'd0;

      // Reset state after two reset edges
      repeat (2) @(negedge clk);
      check("rst_cnt", {25'd0, bus.cnt_value}, 32'd63);
      check("rst_we", {31'd0, bus.write_enable}, 32'd0);
      check("rst_wv", {7'd0, bus.write_value}, 32'd0);
      check("rst_done", {31'd0, bus.donee}, 32'd0);
      rst = 1'b0;

      // Idle with start low
      repeat (10) @(negedge clk);
      check("idle_cnt", {25'd0, bus.cnt_value}, 32'd63);
      check("idle_we", {31'd0, bus.write_enable}, 32'd0);
      check("idle_done", {31'd0, bus.donee}, 32'd0);

      // Single-bit mapping, start dropped mid-run
      for (int i = 0; i < 64; i++) mem[i] = 25'd1 << (i % 25);
      mem[3] = 25'h0000020;
      mem[4] = 25'h1FFFFFF;
      run_full("single_bit", 1'b0);
      if (cap.size() >= 5) begin
         check("lit_slice0", {7'd0, cap[0]}, 32'h0000001);
         check("lit_slice1", {7'd0, cap[1]}, 32'h0000400);
         check("lit_slice2", {7'd0, cap[2]}, 32'h0100000);
         check("lit_slice3", {7'd0, cap[3]}, 32'h0010000);
         check("lit_slice4", {7'd0, cap[4]}, 32'h1FFFFFF);
      end else begin
         check("lit_cap_size", 32'(cap.size()), 32'd64);
      end

      // Random full pass
      do_reset();
      for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
      run_full("random", 1'b1);

      // All ones
      do_reset();
      for (int i = 0; i < 64; i++) mem[i] = 25'h1FFFFFF;
      run_full("ones", 1'b0);
      if (cap.size() == 64) check("lit_ones_last", {7'd0, cap[63]}, 32'h1FFFFFF);
      else check("ones_cap_size", 32'(cap.size()), 32'd64);

      // All zeros
      do_reset();
      for (int i = 0; i < 64; i++) mem[i] = 25'd0;
      run_full("zeros", 1'b0);
      if (cap.size() == 64) check("lit_zeros_last", {7'd0, cap[63]}, 32'h0);
      else check("zeros_cap_size", 32'(cap.size()), 32'd64);

      // Abort during the 20th slice, then restart from slice 0
      do_reset();
      for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (pulse_idx < 19 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_reach", 32'(pulse_idx), 32'd19);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_cnt", {25'd0, bus.cnt_value}, 32'd63);
      check("abort_done", {31'd0, bus.donee}, 32'd0);
      check("abort_we", {31'd0, bus.write_enable}, 32'd0);
      for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
      run_full("restart", 1'b0);

      // Sticky done with start held high
      @(negedge clk);
      bus.start = 1'b1;
      repeat (20) @(negedge clk);
      check("sticky_pulses", 32'(pulse_idx), 32'd64);
      check("sticky_done", {31'd0, bus.donee}, 32'd1);
      bus.start = 1'b0;

      // Second image after reset
      do_reset();
      check("second_done_clear", {31'd0, bus.donee}, 32'd0);
      for (int i = 0; i < 64; i++) mem[i] = 25'($urandom) ^ 25'h0AAAAAA;
      run_full("second_image", 1'b1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
